// File: rtl/sobel_frame_loader.sv
// Serial 1-bit pixel loader feeding mySobel: assembles a WIDTH x HEIGHT frame in a
// shadow buffer and commits it atomically to frame_out. Optional macro: SOF_RESYNC_EN.
module sobel_frame_loader #(
  parameter int WIDTH  = 9,
  parameter int HEIGHT = 9
) (
  input  logic                      dclk,
  input  logic                      clr,
  input  logic                      pix_in,
  input  logic                      pix_valid,
  input  logic                      sof,
  output logic                      pix_ready,
  output logic [0:WIDTH*HEIGHT-1]   frame_out,
  output logic                      frame_valid,
  input  logic                      frame_ack,
  output logic [7:0]                frame_count
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [0:N-1]    r_shadow;
  logic [0:N-1]    r_frame_out;
  logic            r_frame_valid;
  logic [7:0]      r_frame_count;

  logic            w_accept;
  logic            w_slot_free;
  logic            w_commit;
  logic            w_last;
  logic            w_col_end;
  logic [IW-1:0]   w_idx;

  assign pix_ready   = (r_state != FULL);
  assign w_accept    = pix_valid && pix_ready;
  assign w_slot_free = !r_frame_valid || frame_ack;
  assign w_commit    = (r_state == FULL) && w_slot_free;
  assign w_col_end   = (r_col == CW'(WIDTH - 1));
  assign w_last      = w_col_end && (r_row == RW'(HEIGHT - 1));
  assign w_idx       = IW'(int'(r_row) * WIDTH + int'(r_col));

  assign frame_out   = r_frame_out;
  assign frame_valid = r_frame_valid;
  assign frame_count = r_frame_count;

  always_ff @(posedge dclk) begin
    if (clr) begin
      r_state       <= IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_shadow      <= '0;
      r_frame_out   <= '0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Only a start-of-frame pixel opens a frame; anything else is dropped.
          if (w_accept && sof) begin
            r_shadow[0] <= pix_in;
            r_col       <= CW'(1);
            r_row       <= '0;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          if (w_accept) begin
`ifdef SOF_RESYNC_EN
            if (sof && (w_idx != '0)) begin
              r_shadow[0] <= pix_in;
              r_col       <= CW'(1);
              r_row       <= '0;
            end else
`endif
            begin
              r_shadow[w_idx] <= pix_in;
              if (w_last) begin
                r_col   <= '0;
                r_row   <= '0;
                r_state <= FULL;
              end else if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + CW'(1);
              end
            end
          end
        end
        FULL: begin
          if (w_slot_free) begin
            r_frame_out   <= r_shadow;
            r_frame_valid <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // An ack retires the frame unless a fresh commit replaces it on the same edge.
      if (r_frame_valid && frame_ack && !w_commit)
        r_frame_valid <= 1'b0;
    end
  end

endmodule
